// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared definitions for the PmodCLP text source and LCD write engine
package lcd_pkg;

  localparam logic       LCD_RS_CMD    = 1'b0;
  localparam logic       LCD_RS_DATA   = 1'b1;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE1_OFS = 8'h00;
  localparam logic [7:0] LCD_LINE2_OFS = 8'h40;
  localparam logic [7:0] FILL_CHAR     = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR1,
    ST_CHARS1,
    ST_ADDR2,
    ST_CHARS2,
    ST_DONE
  } lcd_state_t;

  function automatic logic [7:0] ddram_cmd(input logic [7:0] ofs);
    return LCD_SET_DDRAM | ofs;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// rtl/lcd_char_ram.sv - character register file, one write port, one async read port
module lcd_char_ram
  import lcd_pkg::*;
#(
  parameter int         DEPTH  = 32,
  parameter int         ADDR_W = 5,
  parameter logic [7:0] FILL   = FILL_CHAR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_text_source.sv
// rtl/lcd_text_source.sv - 2-line text buffer streaming full-screen refresh commands to the LCD driver
module lcd_text_source
  import lcd_pkg::*;
#(
  parameter int         LINE_LEN  = 16,
  parameter int         ADDR_W    = $clog2(2*LINE_LEN),
  parameter logic [7:0] LINE1_CMD = ddram_cmd(LCD_LINE1_OFS),
  parameter logic [7:0] LINE2_CMD = ddram_cmd(LCD_LINE2_OFS),
  parameter logic [7:0] FILL_CHAR = lcd_pkg::FILL_CHAR
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              refresh,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rs,
  output logic [7:0]        cmd_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int                DEPTH      = 2*LINE_LEN;
  localparam logic [ADDR_W-1:0] LINE2_BASE = ADDR_W'(LINE_LEN);
  localparam logic [ADDR_W-1:0] LAST1      = ADDR_W'(LINE_LEN-1);
  localparam logic [ADDR_W-1:0] LAST2      = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  lcd_state_t        state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n, rd_addr;
  logic              dirty, dirty_n, rs_n, xfer, wr_ok;
  logic [7:0]        data_n, rd_data;

  // Non-power-of-two depths leave address codes with no backing entry.
  assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);

  lcd_char_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .FILL   (FILL_CHAR)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (RSTN),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_char),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign xfer       = cmd_valid & cmd_ready;
  assign cmd_valid  = state inside {ST_ADDR1, ST_CHARS1, ST_ADDR2, ST_CHARS2};
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  // The read address always points at the entry that the next transfer will load.
  always_comb begin
    rd_addr = ptr + ONE;
    if (state == ST_ADDR1) rd_addr = '0;
    else if (state == ST_ADDR2) rd_addr = LINE2_BASE;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dirty_n = dirty;
    rs_n    = cmd_rs;
    data_n  = cmd_data;
    unique case (state)
      ST_IDLE: begin
        if (dirty) begin
          dirty_n = 1'b0;
          rs_n    = LCD_RS_CMD;
          data_n  = LINE1_CMD;
          state_n = ST_ADDR1;
        end
      end
      ST_ADDR1: begin
        if (xfer) begin
          rs_n    = LCD_RS_DATA;
          data_n  = rd_data;
          ptr_n   = '0;
          state_n = ST_CHARS1;
        end
      end
      ST_CHARS1: begin
        if (xfer) begin
          if (ptr == LAST1) begin
            rs_n    = LCD_RS_CMD;
            data_n  = LINE2_CMD;
            state_n = ST_ADDR2;
          end else begin
            ptr_n  = ptr + ONE;
            rs_n   = LCD_RS_DATA;
            data_n = rd_data;
          end
        end
      end
      ST_ADDR2: begin
        if (xfer) begin
          rs_n    = LCD_RS_DATA;
          data_n  = rd_data;
          ptr_n   = LINE2_BASE;
          state_n = ST_CHARS2;
        end
      end
      ST_CHARS2: begin
        if (xfer) begin
          if (ptr == LAST2) begin
            state_n = ST_DONE;
          end else begin
            ptr_n  = ptr + ONE;
            rs_n   = LCD_RS_DATA;
            data_n = rd_data;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // A new request in the launch cycle must survive the clear above.
    if (wr_ok || refresh) dirty_n = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      dirty    <= 1'b1;
      cmd_rs   <= LCD_RS_CMD;
      cmd_data <= 8'h00;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      dirty    <= dirty_n;
      cmd_rs   <= rs_n;
      cmd_data <= data_n;
    end
  end

endmodule

// File: tb/tb_lcd_text_source.sv
// tb/tb_lcd_text_source.sv - directed bench for lcd_text_source
module tb_lcd_text_source;

  logic       CLK;
  logic       RSTN;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       refresh;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       frame_done;

  logic       w_wr_en;
  logic [5:0] w_wr_addr;
  logic [7:0] w_wr_char;
  logic       w_refresh;
  logic       w_valid;
  logic       w_ready;
  logic       w_rs;
  logic [7:0] w_data;
  logic       w_busy;
  logic       w_done;

  int total = 0;
  int bad   = 0;

  logic [8:0] log_q[$];
  int         done_cnt;
  int         hold_err;
  bit         timed_out;
  logic [7:0] exp_buf [32];

  lcd_text_source dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .refresh    (refresh),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rs     (cmd_rs),
    .cmd_data   (cmd_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  lcd_text_source #(.LINE_LEN(20)) dut20 (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .wr_en      (w_wr_en),
    .wr_addr    (w_wr_addr),
    .wr_char    (w_wr_char),
    .refresh    (w_refresh),
    .cmd_valid  (w_valid),
    .cmd_ready  (w_ready),
    .cmd_rs     (w_rs),
    .cmd_data   (w_data),
    .busy       (w_busy),
    .frame_done (w_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] exp_word(input int i);
    if (i == 0) return {1'b0, 8'h80};
    if (i <= 16) return {1'b1, exp_buf[i-1]};
    if (i == 17) return {1'b0, 8'hC0};
    return {1'b1, exp_buf[i-2]};
  endfunction

  task automatic blank_model();
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
  endtask

  // Drives cmd_ready, records transfers and stall stability until the DUT sits idle.
  task automatic collect(input int stall_pct, input int budget, input int trig_at,
                         input logic [4:0] t_addr, input logic [7:0] t_char);
    logic       had_stall;
    logic [8:0] held;
    int         quiet;
    bit         fired;
    log_q.delete();
    done_cnt  = 0;
    hold_err  = 0;
    timed_out = 0;
    had_stall = 0;
    held      = '0;
    quiet     = 0;
    fired     = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      wr_en   = 1'b0;
      refresh = 1'b0;
      if (had_stall && (cmd_valid !== 1'b1 || {cmd_rs, cmd_data} !== held)) hold_err++;
      if (frame_done === 1'b1) done_cnt++;
      if (!fired && trig_at >= 0 && log_q.size() == trig_at) begin
        wr_en   = 1'b1;
        wr_addr = t_addr;
        wr_char = t_char;
        fired   = 1;
      end
      cmd_ready = ($urandom_range(0, 99) >= stall_pct);
      if (cmd_valid === 1'b1 && cmd_ready) log_q.push_back({cmd_rs, cmd_data});
      had_stall = (cmd_valid === 1'b1) && !cmd_ready;
      held      = {cmd_rs, cmd_data};
      quiet     = (busy === 1'b0 && cmd_valid === 1'b0) ? quiet + 1 : 0;
      if (quiet >= 3) return;
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    RSTN = 1'b1; wr_en = 0; wr_addr = 0; wr_char = 0; refresh = 0; cmd_ready = 1;
    w_wr_en = 0; w_wr_addr = 0; w_wr_char = 0; w_refresh = 0; w_ready = 1;
    #2 RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    total++; if (cmd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs: got %b expected 0", cmd_rs); end
    total++; if (cmd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", cmd_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    blank_model();
    RSTN = 1'b1;
    collect(0, 300, -1, 5'd0, 8'd0);
    total++; if (timed_out || log_q.size() != 34) begin bad++; $display("FAIL boot_len: got %0d expected 34", log_q.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL boot_done: got %0d expected 1", done_cnt); end
    begin
      int errs = 0;
      for (int i = 0; i < 34 && i < log_q.size(); i++) if (log_q[i] !== exp_word(i)) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL boot_frame: got %0d wrong words expected 0", errs); end
    end
  endtask

  task automatic test_write_chars();
    int errs = 0;
    @(negedge CLK); wr_en = 1; wr_addr = 5'd0;  wr_char = 8'h48;
    @(negedge CLK); wr_en = 1; wr_addr = 5'd16; wr_char = 8'h69;
    exp_buf[0] = 8'h48; exp_buf[16] = 8'h69;
    collect(0, 400, -1, 5'd0, 8'd0);
    total++; if (done_cnt != 2 || log_q.size() != 68) begin bad++; $display("FAIL write_frames: got %0d/%0d expected 2/68", done_cnt, log_q.size()); end
    total++; if (log_q.size() < 2 || log_q[1] !== 9'h148) begin bad++; $display("FAIL write_h: got %h expected 148", log_q.size() > 1 ? log_q[1] : 9'h0); end
    total++; if (log_q.size() < 19 || log_q[18] !== 9'h169) begin bad++; $display("FAIL write_i: got %h expected 169", log_q.size() > 18 ? log_q[18] : 9'h0); end
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] !== exp_word(i % 34)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL write_content: got %0d wrong words expected 0", errs); end
  endtask

  task automatic test_backpressure();
    int errs = 0;
    @(negedge CLK); refresh = 1;
    collect(50, 2000, -1, 5'd0, 8'd0);
    total++; if (timed_out || log_q.size() != 34) begin bad++; $display("FAIL bp_len: got %0d expected 34", log_q.size()); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 34 && i < log_q.size(); i++) if (log_q[i] !== exp_word(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_content: got %0d wrong words expected 0", errs); end
  endtask

  task automatic test_write_midframe();
    int errs = 0;
    @(negedge CLK); refresh = 1;
    collect(0, 400, 11, 5'd5, 8'h58);
    total++; if (done_cnt != 2 || log_q.size() != 68) begin bad++; $display("FAIL mid_frames: got %0d/%0d expected 2/68", done_cnt, log_q.size()); end
    for (int i = 0; i < 34 && i < log_q.size(); i++) if (log_q[i] !== exp_word(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL mid_old_frame: got %0d wrong words expected 0", errs); end
    exp_buf[5] = 8'h58;
    errs = 0;
    for (int i = 34; i < log_q.size(); i++) if (log_q[i] !== exp_word(i - 34)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL mid_new_frame: got %0d wrong words expected 0", errs); end
    total++; if (log_q.size() < 41 || log_q[40] !== 9'h158) begin bad++; $display("FAIL mid_new_char: got %h expected 158", log_q.size() > 40 ? log_q[40] : 9'h0); end
  endtask

  task automatic test_launch_collision();
    int errs = 0;
    @(negedge CLK); refresh = 1;
    @(negedge CLK); refresh = 1; wr_en = 1; wr_addr = 5'd3; wr_char = 8'h41;
    exp_buf[3] = 8'h41;
    collect(0, 400, -1, 5'd0, 8'd0);
    total++; if (done_cnt != 2 || log_q.size() != 68) begin bad++; $display("FAIL launch_frames: got %0d/%0d expected 2/68", done_cnt, log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] !== exp_word(i % 34)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL launch_content: got %0d wrong words expected 0", errs); end
  endtask

  task automatic test_reset_midframe();
    int errs = 0;
    @(negedge CLK); refresh = 1; cmd_ready = 1;
    @(negedge CLK); refresh = 0;
    repeat (22) @(negedge CLK);
    total++; if (busy !== 1'b1 || cmd_rs !== 1'b1 || cmd_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: got busy=%b rs=%b valid=%b expected 1 1 1", busy, cmd_rs, cmd_valid); end
    #2 RSTN = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_async: got valid=%b busy=%b expected 0 0", cmd_valid, busy); end
    total++; if (cmd_data !== 8'h00 || cmd_rs !== 1'b0) begin bad++; $display("FAIL rst_cmd: got %b/%h expected 0/00", cmd_rs, cmd_data); end
    blank_model();
    @(negedge CLK); RSTN = 1'b1;
    collect(0, 300, -1, 5'd0, 8'd0);
    total++; if (done_cnt != 1 || log_q.size() != 34) begin bad++; $display("FAIL rst_frames: got %0d/%0d expected 1/34", done_cnt, log_q.size()); end
    for (int i = 0; i < 34 && i < log_q.size(); i++) if (log_q[i] !== exp_word(i)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL rst_blank: got %0d wrong words expected 0", errs); end
  endtask

  task automatic test_out_of_range();
    logic [8:0] wq[$];
    int quiet = 0;
    int busy_seen = 0;
    int nonblank = 0;
    bit got_done = 0;
    for (int c = 0; c < 300 && quiet < 3; c++) begin
      @(negedge CLK);
      quiet = (w_busy === 1'b0) ? quiet + 1 : 0;
    end
    total++; if (quiet < 3) begin bad++; $display("FAIL oor_settle: got busy=%b expected 0", w_busy); end
    @(negedge CLK); w_wr_en = 1; w_wr_addr = 6'd40; w_wr_char = 8'h51;
    @(negedge CLK); w_wr_en = 0;
    repeat (6) begin
      @(negedge CLK);
      if (w_busy !== 1'b0) busy_seen++;
    end
    total++; if (busy_seen != 0) begin bad++; $display("FAIL oor_ignored: got %0d busy cycles expected 0", busy_seen); end
    @(negedge CLK); w_wr_en = 1; w_wr_addr = 6'd39; w_wr_char = 8'h5A;
    @(negedge CLK); w_wr_en = 0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (w_valid === 1'b1 && w_ready) wq.push_back({w_rs, w_data});
      if (w_done === 1'b1) got_done = 1;
      @(negedge CLK);
    end
    total++; if (!got_done || wq.size() != 42) begin bad++; $display("FAIL oor_len: got %0d expected 42", wq.size()); end
    total++; if (wq.size() < 42 || wq[41] !== 9'h15A || wq[21] !== 9'h0C0) begin bad++; $display("FAIL oor_last: got %h expected 15a", wq.size() > 41 ? wq[41] : 9'h0); end
    for (int i = 0; i < wq.size(); i++) if (wq[i][8] && wq[i][7:0] !== 8'h20) nonblank++;
    total++; if (nonblank != 1) begin bad++; $display("FAIL oor_buffer: got %0d non-blank chars expected 1", nonblank); end
  endtask

  initial begin
    test_reset();
    test_write_chars();
    test_backpressure();
    test_write_midframe();
    test_launch_collision();
    test_reset_midframe();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
